// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_pkg
// Description : Shared types and constants for the 8-bit single-cycle CPU:
//               NZCV flag bit positions, condition codes, ShowR scan states.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    // NZCV bit positions inside the 4-bit flag word
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    // Instruction condition field encodings
    typedef enum logic [3:0] {
        COND_AL = 4'd0,
        COND_EQ = 4'd1,
        COND_NE = 4'd2,
        COND_CS = 4'd3,
        COND_CC = 4'd4,
        COND_MI = 4'd5,
        COND_PL = 4'd6,
        COND_VS = 4'd7,
        COND_VC = 4'd8,
        COND_GT = 4'd9,
        COND_GE = 4'd10,
        COND_LT = 4'd11,
        COND_LE = 4'd12,
        COND_HI = 4'd13,
        COND_LS = 4'd14,
        COND_NV = 4'd15
    } cond_t;

    // ShowR scan engine states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        FLAGS = 2'd2
    } show_state_t;

    // Debug index used for the trailing flags beat
    localparam logic [3:0] DBG_FLAGS_IDX = 4'd8;

endpackage : cpu_pkg
`default_nettype wire

// File: rtl/cond_check.sv
`default_nettype none
// ============================================================================
// Module      : cond_check
// Description : Combinational condition-code evaluator. Decides whether an
//               instruction with condition field `cond` executes given NZCV.
//               Kept standalone so the branch unit can reuse it.
// Revision    : 1.0 - initial release
// ============================================================================
module cond_check
    import cpu_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       cond_ex
);

    logic n, z, c, v;

    assign n = flags[FLAG_N];
    assign z = flags[FLAG_Z];
    assign c = flags[FLAG_C];
    assign v = flags[FLAG_V];

    // Decode the condition field against the supplied flags
    always_comb begin
        cond_ex = 1'b0;
        case (cond_t'(cond))
            COND_AL: cond_ex = 1'b1;
            COND_EQ: cond_ex = z;
            COND_NE: cond_ex = ~z;
            COND_CS: cond_ex = c;
            COND_CC: cond_ex = ~c;
            COND_MI: cond_ex = n;
            COND_PL: cond_ex = ~n;
            COND_VS: cond_ex = v;
            COND_VC: cond_ex = ~v;
            COND_GT: cond_ex = ~z & (n == v);
            COND_GE: cond_ex = (n == v);
            COND_LT: cond_ex = (n != v);
            COND_LE: cond_ex = z | (n != v);
            COND_HI: cond_ex = c & ~z;
            COND_LS: cond_ex = ~c | z;
            COND_NV: cond_ex = 1'b0;
            default: cond_ex = 1'b0;
        endcase
    end

endmodule : cond_check
`default_nettype wire

// File: rtl/regfile_wb.sv
`default_nettype none
// ============================================================================
// Module      : regfile_wb
// Description : Write-back stage: 8x8 register file with a second write port
//               for XCHG, NZCV flag register, condition gating of all writes,
//               and a handshaked ShowR scan streaming registers then flags.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_wb
    import cpu_pkg::*;
#(
    parameter int DW   = 8,
    parameter int NREG = 8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [$clog2(NREG)-1:0]  ra1,
    input  logic [$clog2(NREG)-1:0]  ra2,
    output logic [DW-1:0]            rd1,
    output logic [DW-1:0]            rd2,
    input  logic [$clog2(NREG)-1:0]  wa3,
    input  logic [DW-1:0]            wd3,
    input  logic                     we3,
    input  logic [$clog2(NREG)-1:0]  wa4,
    input  logic [DW-1:0]            wd4,
    input  logic                     we4,
    input  logic [3:0]               flags_in,
    input  logic                     flags_we,
    input  logic [3:0]               cond,
    output logic                     cond_ex,
    output logic [3:0]               flags,
    input  logic                     show_req,
    output logic                     show_busy,
    output logic                     dbg_valid,
    input  logic                     dbg_ready,
    output logic [3:0]               dbg_idx,
    output logic [DW-1:0]            dbg_data
);

    localparam int AW = $clog2(NREG);
    localparam logic [3:0] LAST_REG_IDX = 4'(NREG - 1);

    logic [DW-1:0] regs [NREG];
    show_state_t   state;
    logic          we3_eff;
    logic          we4_eff;
    logic          flags_we_eff;

    // Condition is judged on the registered flags, never on flags_in
    cond_check u_cond_check (
        .cond    (cond),
        .flags   (flags),
        .cond_ex (cond_ex)
    );

    assign we3_eff      = we3 & cond_ex;
    assign we4_eff      = we4 & cond_ex;
    assign flags_we_eff = flags_we & cond_ex;

    // Reads are combinational from the array: no write-through bypass
    assign rd1 = regs[ra1];
    assign rd2 = regs[ra2];

    // Register array update; port 3 assigned last so it wins on equal addresses
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (we4_eff) begin
                regs[wa4] <= wd4;
            end
            if (we3_eff) begin
                regs[wa3] <= wd3;
            end
        end
    end

    // NZCV flag register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            flags <= 4'b0000;
        end else if (flags_we_eff) begin
            flags <= flags_in;
        end
    end

    // ShowR scan engine: walk r0..r(NREG-1), then one flags beat
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            dbg_idx   <= 4'd0;
            dbg_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (show_req) begin
                        state     <= SCAN;
                        dbg_idx   <= 4'd0;
                        dbg_valid <= 1'b1;
                    end
                end
                SCAN: begin
                    if (dbg_ready) begin
                        if (dbg_idx == LAST_REG_IDX) begin
                            state   <= FLAGS;
                            dbg_idx <= DBG_FLAGS_IDX;
                        end else begin
                            dbg_idx <= dbg_idx + 4'd1;
                        end
                    end
                end
                FLAGS: begin
                    if (dbg_ready) begin
                        state     <= IDLE;
                        dbg_idx   <= 4'd0;
                        dbg_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    dbg_idx   <= 4'd0;
                    dbg_valid <= 1'b0;
                end
            endcase
        end
    end

    assign show_busy = (state != IDLE);

    // Beat data is live: it follows the current content of the indexed entry
    assign dbg_data = (dbg_idx == DBG_FLAGS_IDX) ? {{(DW-4){1'b0}}, flags}
                                                 : regs[dbg_idx[AW-1:0]];

endmodule : regfile_wb
`default_nettype wire

// File: tb/tb_regfile_wb.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_wb
// Description : Directed self-checking bench for regfile_wb.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_wb;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [2:0] ra1, ra2, wa3, wa4;
    logic [7:0] rd1, rd2, wd3, wd4;
    logic       we3, we4;
    logic [3:0] flags_in;
    logic       flags_we;
    logic [3:0] cond;
    logic       cond_ex;
    logic [3:0] flags;
    logic       show_req, show_busy, dbg_valid, dbg_ready;
    logic [3:0] dbg_idx;
    logic [7:0] dbg_data;

    int total = 0;
    int bad   = 0;

    regfile_wb #(.DW(8), .NREG(8)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .ra1       (ra1),
        .ra2       (ra2),
        .rd1       (rd1),
        .rd2       (rd2),
        .wa3       (wa3),
        .wd3       (wd3),
        .we3       (we3),
        .wa4       (wa4),
        .wd4       (wd4),
        .we4       (we4),
        .flags_in  (flags_in),
        .flags_we  (flags_we),
        .cond      (cond),
        .cond_ex   (cond_ex),
        .flags     (flags),
        .show_req  (show_req),
        .show_busy (show_busy),
        .dbg_valid (dbg_valid),
        .dbg_ready (dbg_ready),
        .dbg_idx   (dbg_idx),
        .dbg_data  (dbg_data)
    );

    always #5 clk = ~clk;

    task test_reset;
        reset_n = 1'b0;
        ra1 = 3'd0; ra2 = 3'd0; wa3 = 3'd0; wa4 = 3'd0;
        wd3 = 8'h00; wd4 = 8'h00; we3 = 1'b0; we4 = 1'b0;
        flags_in = 4'h0; flags_we = 1'b0; cond = 4'd0;
        show_req = 1'b0; dbg_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        for (int a = 0; a < 8; a++) begin
            ra1 = 3'(a);
            ra2 = 3'(7 - a);
            #1;
            total++;
            if (rd1 !== 8'h00 || rd2 !== 8'h00) begin
                bad++;
                $display("FAIL reset_read a=%0d: rd1=%h rd2=%h expected 00 00", a, rd1, rd2);
            end
        end
        total++;
        if (flags !== 4'b0000) begin
            bad++;
            $display("FAIL reset_flags: got %b expected 0000", flags);
        end
        total++;
        if (dbg_valid !== 1'b0 || show_busy !== 1'b0 || dbg_idx !== 4'd0) begin
            bad++;
            $display("FAIL reset_scan: valid=%b busy=%b idx=%0d expected 0 0 0", dbg_valid, show_busy, dbg_idx);
        end
        cond = 4'd0;
        #1;
        total++;
        if (cond_ex !== 1'b1) begin
            bad++;
            $display("FAIL reset_cond_al: got %b expected 1", cond_ex);
        end
        cond = 4'd15;
        #1;
        total++;
        if (cond_ex !== 1'b0) begin
            bad++;
            $display("FAIL reset_cond_nv: got %b expected 0", cond_ex);
        end
        @(negedge clk);
        cond = 4'd0;
        reset_n = 1'b1;
    endtask

    task test_write;
        @(negedge clk);
        we3 = 1'b1; wa3 = 3'd2; wd3 = 8'h5A; cond = 4'd0; ra1 = 3'd2;
        #1;
        total++;
        if (rd1 !== 8'h00) begin
            bad++;
            $display("FAIL write_before_edge: got %h expected 00", rd1);
        end
        @(posedge clk);
        #1;
        total++;
        if (rd1 !== 8'h5A) begin
            bad++;
            $display("FAIL write_after_edge: got %h expected 5a", rd1);
        end
        @(negedge clk);
        we3 = 1'b0;
    endtask

    task test_xchg;
        @(negedge clk);
        we3 = 1'b1; wa3 = 3'd1; wd3 = 8'h11;
        we4 = 1'b1; wa4 = 3'd4; wd4 = 8'h44;
        @(posedge clk);
        #1;
        ra1 = 3'd1; ra2 = 3'd4;
        #1;
        total++;
        if (rd1 !== 8'h11 || rd2 !== 8'h44) begin
            bad++;
            $display("FAIL xchg_dual: r1=%h r4=%h expected 11 44", rd1, rd2);
        end
        @(negedge clk);
        wa3 = 3'd3; wd3 = 8'h33;
        wa4 = 3'd3; wd4 = 8'h77;
        @(posedge clk);
        #1;
        ra1 = 3'd3;
        #1;
        total++;
        if (rd1 !== 8'h33) begin
            bad++;
            $display("FAIL xchg_collide: r3=%h expected 33", rd1);
        end
        @(negedge clk);
        we3 = 1'b0; we4 = 1'b0;
    endtask

    task test_flags;
        @(negedge clk);
        flags_in = 4'b0100; flags_we = 1'b1; cond = 4'd0;
        @(posedge clk);
        #1;
        total++;
        if (flags !== 4'b0100) begin
            bad++;
            $display("FAIL flags_update: got %b expected 0100", flags);
        end
        @(negedge clk);
        flags_we = 1'b0; cond = 4'd1;
        we3 = 1'b1; wa3 = 3'd5; wd3 = 8'hA5; ra1 = 3'd5;
        #1;
        total++;
        if (cond_ex !== 1'b1) begin
            bad++;
            $display("FAIL flags_eq_ex: got %b expected 1", cond_ex);
        end
        @(posedge clk);
        #1;
        total++;
        if (rd1 !== 8'hA5) begin
            bad++;
            $display("FAIL flags_eq_write: got %h expected a5", rd1);
        end
        // NE fails on registered Z=1 even though flags_in shows Z=0
        @(negedge clk);
        cond = 4'd2; wd3 = 8'h00;
        flags_we = 1'b1; flags_in = 4'b1000;
        #1;
        total++;
        if (cond_ex !== 1'b0) begin
            bad++;
            $display("FAIL flags_ne_ex: got %b expected 0", cond_ex);
        end
        @(posedge clk);
        #1;
        total++;
        if (rd1 !== 8'hA5 || flags !== 4'b0100) begin
            bad++;
            $display("FAIL flags_ne_blocked: r5=%h flags=%b expected a5 0100", rd1, flags);
        end
        @(negedge clk);
        we3 = 1'b0; flags_we = 1'b0; cond = 4'd0;
    endtask

    task test_cond;
        logic [3:0] codes [8];
        logic       expv  [8];
        codes = '{4'd9, 4'd10, 4'd11, 4'd12, 4'd13, 4'd14, 4'd5, 4'd4};
        expv  = '{1'b0, 1'b0,  1'b1,  1'b1,  1'b1,  1'b0,  1'b1, 1'b0};
        @(negedge clk);
        cond = 4'd0; flags_in = 4'b1010; flags_we = 1'b1;
        @(posedge clk);
        @(negedge clk);
        flags_we = 1'b0;
        total++;
        if (flags !== 4'b1010) begin
            bad++;
            $display("FAIL cond_setup_flags: got %b expected 1010", flags);
        end
        for (int i = 0; i < 8; i++) begin
            cond = codes[i];
            #1;
            total++;
            if (cond_ex !== expv[i]) begin
                bad++;
                $display("FAIL cond_code_%0d: got %b expected %b", codes[i], cond_ex, expv[i]);
            end
        end
        cond = 4'd0;
    endtask

    task test_showr;
        int k;
        int c;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            we3 = 1'b1; wa3 = 3'(i); wd3 = 8'h10 + 8'(i); cond = 4'd0;
            @(posedge clk);
        end
        @(negedge clk);
        we3 = 1'b0; dbg_ready = 1'b0; show_req = 1'b1;
        @(posedge clk);
        @(negedge clk);
        show_req = 1'b0;
        k = 0;
        c = 0;
        while (k < 9 && c < 40) begin
            total++;
            if (dbg_valid !== 1'b1 || show_busy !== 1'b1 || dbg_idx !== 4'(k) ||
                dbg_data !== ((k < 8) ? (8'h10 + 8'(k)) : 8'h0A)) begin
                bad++;
                $display("FAIL showr_beat c=%0d: valid=%b busy=%b idx=%0d data=%h expected 1 1 %0d %h",
                         c, dbg_valid, show_busy, dbg_idx, dbg_data, k,
                         (k < 8) ? (8'h10 + 8'(k)) : 8'h0A);
            end
            dbg_ready = (c % 2 == 0);
            show_req  = (c == 3);
            @(posedge clk);
            if (dbg_ready) k++;
            c++;
            @(negedge clk);
        end
        dbg_ready = 1'b0;
        show_req  = 1'b0;
        total++;
        if (k != 9) begin
            bad++;
            $display("FAIL showr_timeout: beats=%0d expected 9", k);
        end
        total++;
        if (dbg_valid !== 1'b0 || show_busy !== 1'b0) begin
            bad++;
            $display("FAIL showr_end: valid=%b busy=%b expected 0 0", dbg_valid, show_busy);
        end
    endtask

    task test_back_to_back;
        @(negedge clk);
        dbg_ready = 1'b1; show_req = 1'b1;
        @(posedge clk);
        @(negedge clk);
        show_req = 1'b0;
        for (int n = 0; n < 9; n++) begin
            total++;
            if (dbg_valid !== 1'b1 || dbg_idx !== 4'(n)) begin
                bad++;
                $display("FAIL b2b_beat n=%0d: valid=%b idx=%0d expected 1 %0d", n, dbg_valid, dbg_idx, n);
            end
            @(posedge clk);
            @(negedge clk);
        end
        total++;
        if (show_busy !== 1'b0 || dbg_valid !== 1'b0) begin
            bad++;
            $display("FAIL b2b_done: busy=%b valid=%b expected 0 0", show_busy, dbg_valid);
        end
        dbg_ready = 1'b0;
    endtask

    task test_reset_mid_scan;
        @(negedge clk);
        dbg_ready = 1'b1; show_req = 1'b1;
        @(posedge clk);
        @(negedge clk);
        show_req = 1'b0;
        repeat (4) begin
            @(posedge clk);
            @(negedge clk);
        end
        dbg_ready = 1'b0;
        total++;
        if (dbg_valid !== 1'b1 || dbg_idx !== 4'd4 || dbg_data !== 8'h14) begin
            bad++;
            $display("FAIL midscan_beat4: valid=%b idx=%0d data=%h expected 1 4 14", dbg_valid, dbg_idx, dbg_data);
        end
        reset_n = 1'b0;
        ra1 = 3'd7;
        #1;
        total++;
        if (dbg_valid !== 1'b0 || show_busy !== 1'b0 || dbg_idx !== 4'd0) begin
            bad++;
            $display("FAIL midscan_reset: valid=%b busy=%b idx=%0d expected 0 0 0", dbg_valid, show_busy, dbg_idx);
        end
        total++;
        if (rd1 !== 8'h00 || flags !== 4'b0000) begin
            bad++;
            $display("FAIL midscan_state_clear: r7=%h flags=%b expected 00 0000", rd1, flags);
        end
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        test_reset;
        test_write;
        test_xchg;
        test_flags;
        test_cond;
        test_showr;
        test_back_to_back;
        test_reset_mid_scan;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_regfile_wb
`default_nettype wire

// File: doc/regfile_wb.md
# regfile_wb

Write-back stage of the 8-bit single-cycle processor, directly downstream of the ALU. It holds the 8×8 general register file, with a second write port for XCHG's `ALUResult2`, and the NZCV flag register fed by `ALUFlags`. It evaluates the instruction condition code that gates every write. A handshaked ShowR scan engine streams all registers and flags to the debug/display block.

## Interface
Parameters:
- `DW`, 8, data width; equals ALU result width.
- `NREG`, 8, register count; address width is `$clog2(NREG)`, which is 3.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `ra1`, `ra2` in 3: read addresses.
- `rd1`, `rd2` out 8: read data, combinational from the register array.
- `wa3` in 3, `wd3` in 8, `we3` in 1: primary write port; `wd3` = `ALUResult`.
- `wa4` in 3, `wd4` in 8, `we4` in 1: secondary write port for XCHG; `wd4` = `ALUResult2`.
- `flags_in` in 4: `ALUFlags`; bit 3 = N, 2 = Z, 1 = C, 0 = V.
- `flags_we` in 1: flag update request.
- `cond` in 4: condition field of the current instruction.
- `cond_ex` out 1: condition passes against registered flags.
- `flags` out 4: registered NZCV.
- `show_req` in 1: start a ShowR scan (single-cycle pulse).
- `show_busy` out 1: scan in progress.
- `dbg_valid` out 1, `dbg_ready` in 1: scan output handshake.
- `dbg_idx` out 4: 0–7 register index; 8 = flags beat.
- `dbg_data` out 8: register value; `{4'b0, flags}` on the flags beat.

## Operation
- Every write (`we3`, `we4`, `flags_we`) is qualified by `cond_ex`. Effective enable = request & `cond_ex`.
- `cond_ex` decode:
  - 0 AL → 1
  - 1 EQ → Z
  - 2 NE → !Z
  - 3 CS → C
  - 4 CC → !C
  - 5 MI → N
  - 6 PL → !N
  - 7 VS → V
  - 8 VC → !V
  - 9 GT → !Z & (N==V)
  - 10 GE → N==V
  - 11 LT → N!=V
  - 12 LE → Z | (N!=V)
  - 13 HI → C & !Z
  - 14 LS → !C | Z
  - 15 NV → 0
- `cond_ex` is evaluated on the registered `flags`, never on `flags_in`.
- Port 3 and port 4 write in the same cycle when both are enabled (XCHG).
  - If `wa3 == wa4`, port 3 wins.
- No register is hardwired.
- Reads have no write-through: a write is visible on `rd1`/`rd2` only after the edge.
- ShowR FSM states:
  - IDLE: `show_req` → SCAN with idx = 0.
  - SCAN: `dbg_valid` = 1. On `dbg_valid & dbg_ready`: idx++; after idx 7 → FLAGS.
  - FLAGS: `dbg_valid` = 1 with `dbg_idx` = 8. On handshake → IDLE.
- `show_busy` = state != IDLE.
- `show_req` while busy is ignored.
- `dbg_data` is live: it shows the current content of the indexed register. A write to that register during a stalled beat changes `dbg_data` while valid is held. This is accepted behaviour.
- `dbg_idx`/`dbg_data` must not change while `dbg_valid & !dbg_ready`, except through the live-content rule above.
- The scan never stalls or blocks processor writes.

## Timing
- Reset (async assert, sync release) values:
  - all registers 0x00
  - `flags` 0000
  - FSM IDLE
  - `dbg_valid` 0, `dbg_idx` 0, `show_busy` 0
- Register write latency: 1 edge.
- Flag update latency: 1 edge; `cond_ex` reflects the new flags in the next cycle.
- Scan: first beat `dbg_valid` appears 1 cycle after the `show_req` edge. With `dbg_ready` held at 1, 9 beats take 9 consecutive cycles, and `show_busy` deasserts on the cycle after the last beat.
- Reset asserted mid-scan → immediate IDLE, `dbg_valid` 0. No partial beat survives.
- `dbg_ready` is ignored when `dbg_valid` is 0.

## Structure
- Shared package `cpu_pkg`:
  - `FLAG_N`/`FLAG_Z`/`FLAG_C`/`FLAG_V` bit indices
  - `cond_t` enum of the 16 codes
  - `show_state_t` enum {IDLE, SCAN, FLAGS}
  - `DBG_FLAGS_IDX` = 8
- One sub-module, `cond_check`: combinational `cond` + `flags` → `cond_ex`. The future branch unit reuses it.

## Test plan
- Reset then read all addresses → `rd1`/`rd2` = 0x00, `flags` = 0, `cond_ex` = 1 for AL and 0 for NV.
- `we3`, `wa3` = 2, `wd3` = 0x5A, `cond` = AL → `rd1` (ra1 = 2) = 0x5A after the edge, 0x00 before it.
- XCHG: `wa3` = 1 with `wd3` = 0x11, `wa4` = 4 with `wd4` = 0x44, same cycle → r1 = 0x11, r4 = 0x44. Repeat with `wa3` = `wa4` = 3 → r3 = `wd3`.
- `flags_in` = 0100 (Z) with `flags_we` → `flags` = 0100. Next cycle `cond` = EQ with `we3` writes; `cond` = NE with `we3` leaves the register unchanged and `flags_we` has no effect.
- `flags` N = 1, V = 0 → GE = 0, LT = 1, LE = 1, GT = 0. C = 1, Z = 0 → HI = 1, LS = 0.
- ShowR with r0..r7 = 0x10..0x17 and `dbg_ready` toggling 1,0,1,… → beats idx 0..8 in order with data 0x10..0x17 then `{0, flags}`, each held while not ready. `show_req` mid-scan is ignored. `reset_n` low at beat 4 → `dbg_valid` 0 immediately.
